ext_sram_arbiter: RTL and testbench
===================================

// Module: ext_sram_arbiter
// PURPOSE
// - Parametrised external async-SRAM controller/arbiter for the board-level PCXT tops; replaces direct single-master SRAM wiring.
// - Arbitrates NUM_CH requesters (CPU/chipset, DMA, video, ...) onto one SRAM port.
// - Generates timed SETUP/ACCESS/HOLD cycles so the same RTL serves 512KB/1MB/2MB boards via ADDR_W.
// - Data-bus tristate is split into out/oe and resolved in the top.
// PARAMETERS
// - ADDR_W       21  SRAM address width (21 = 2MB)
// - DATA_W       8   SRAM data width
// - NUM_CH       2   requester count, >=1
// - WAIT_CYCLES  2   ACCESS-phase length in clk_chipset cycles, >=1
// - RR_MODE      1   1 = round-robin arbitration, 0 = fixed priority (ch0 highest)
// PORTS
// - clk_chipset  in   1                single clock, all logic on rising edge
// - reset        in   1                synchronous, active-high
// - req          in   NUM_CH           per-channel request, held until ack
// - we           in   NUM_CH           per-channel 1=write, 0=read
// - addr         in   NUM_CH*ADDR_W    ch i at [i*ADDR_W +: ADDR_W]
// - wdata        in   NUM_CH*DATA_W    ch i at [i*DATA_W +: DATA_W]
// - ack          out  NUM_CH           one-cycle completion pulse to granted channel
// - rdata        out  DATA_W           read data, valid in ack cycle, held until next read completes
// - SRAM_ADDR    out  ADDR_W           registered address
// - SRAM_DQ_O    out  DATA_W           registered write data
// - SRAM_DQ_OE   out  1                1 = drive SRAM data bus
// - SRAM_DQ_I    in   DATA_W           SRAM data bus input
// - SRAM_WE_n    out  1                registered write strobe, active low
// BEHAVIOUR
// - Reset values: state=IDLE, SRAM_WE_n=1, SRAM_DQ_OE=0, ack=0, rdata=0, SRAM_ADDR=0, SRAM_DQ_O=0.
// - Reset: RR pointer=NUM_CH-1, so ch0 wins the first RR arbitration.
// - Reset mid-transaction: next edge returns to IDLE, forces SRAM_WE_n=1 and OE=0, and emits no ack.
// - IDLE: when any req is high, pick a winner and latch its ch/we/addr/wdata; next state SETUP.
// - Arbitration, RR_MODE=1: scan from pointer+1 upward with wrap; pointer := winner.
// - Arbitration, RR_MODE=0: lowest-index req wins.
// - SETUP (1 cycle): SRAM_ADDR valid, SRAM_WE_n=1, SRAM_DQ_OE=latched we.
// - ACCESS (WAIT_CYCLES cycles, down-counter):
//   - write: SRAM_WE_n=0, OE=1.
//   - read: OE=0; rdata captures SRAM_DQ_I on the last ACCESS cycle edge.
// - HOLD (1 cycle): SRAM_WE_n=1, address held; OE stays 1 for writes (data hold time).
//   ack[ch]=1 this cycle only. Next state always IDLE, so the acked req is not re-granted.
// - Latency: req seen in IDLE at cycle 0 -> SETUP cycle 1 -> ACCESS cycles 2..WAIT_CYCLES+1 -> ack in cycle WAIT_CYCLES+2.
// - Throughput: 1 access per WAIT_CYCLES+4 cycles, including the IDLE turnaround.
// - Inputs are sampled only in IDLE. A req or addr change after grant does not affect the running access.
// - Dropped req: if the granted req falls mid-access, the access still completes and ack still pulses.
// - Simultaneous reqs: exactly one grant per arbitration; losers stay pending, never lost or acked.
// - ack is one-hot or zero at all times.
// - SRAM_WE_n is never low while OE=0, and never low in SETUP or HOLD.
// - NUM_CH=1: arbitration degenerates to pass-through; RR pointer is unused.
// TESTING
// - Reset then idle: all outputs at reset values; no ack for 20 cycles with req=0.
// - Ch0 write, addr=0x1ABCD, wdata=0x5A, W=2: SETUP c1, WE_n low c2-c3, ack[0] c4; SRAM model holds 0x5A.
// - Ch1 read of 0x1ABCD after that write: rdata=0x5A with ack[1] in cycle 4; OE=0 throughout.
// - RR_MODE=1, req=2'b11 held: grants alternate ch0,ch1,ch0,ch1 with 6-cycle spacing.
// - RR_MODE=0, same stimulus: ch0 is always served; ch1 is acked only after ch0 drops req.
// - Reset asserted in the second ACCESS cycle of a write: WE_n=1 and OE=0 next cycle, no ack; next request behaves normally.

Source files
------------

// File: rtl/ext_sram_arbiter.sv
// External async-SRAM controller: arbitrates NUM_CH requesters onto one SRAM port
// and sequences each access as SETUP / ACCESS (WAIT_CYCLES) / HOLD.
module ext_sram_arbiter #(
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned RR_MODE     = 1
) (
    input  logic                     clk_chipset,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        ack,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        SRAM_ADDR,
    output logic [DATA_W-1:0]        SRAM_DQ_O,
    output logic                     SRAM_DQ_OE,
    input  logic [DATA_W-1:0]        SRAM_DQ_I,
    output logic                     SRAM_WE_n
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t            state;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   ch_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic              turn;
    logic [CH_W-1:0]   win_c;
    logic [CH_W-1:0]   idx_c;

    // Descending scan so the candidate closest to the scan start is the last hit and wins.
    always_comb begin
        win_c = '0;
        idx_c = '0;
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            if (RR_MODE != 0)
                idx_c = CH_W'((32'(ptr) + k) % NUM_CH);
            else
                idx_c = CH_W'(k - 1);
            if (req[idx_c])
                win_c = idx_c;
        end
    end

    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            state      <= IDLE;
            SRAM_WE_n  <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
            ack        <= '0;
            rdata      <= '0;
            SRAM_ADDR  <= '0;
            SRAM_DQ_O  <= '0;
            ptr        <= CH_W'(NUM_CH - 1);
            ch_q       <= '0;
            we_q       <= 1'b0;
            cnt        <= '0;
            turn       <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                // One idle cycle after every access gives the bus turnaround slot.
                IDLE: begin
                    SRAM_WE_n  <= 1'b1;
                    SRAM_DQ_OE <= 1'b0;
                    if (turn) begin
                        turn <= 1'b0;
                    end else if (|req) begin
                        ch_q       <= win_c;
                        we_q       <= we[win_c];
                        SRAM_ADDR  <= addr[32'(win_c)*ADDR_W +: ADDR_W];
                        SRAM_DQ_O  <= wdata[32'(win_c)*DATA_W +: DATA_W];
                        SRAM_DQ_OE <= we[win_c];
                        ptr        <= win_c;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    SRAM_WE_n <= ~we_q;
                    cnt       <= CNT_W'(WAIT_CYCLES - 1);
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        SRAM_WE_n  <= 1'b1;
                        ack[ch_q]  <= 1'b1;
                        if (!we_q)
                            rdata <= SRAM_DQ_I;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    SRAM_DQ_OE <= 1'b0;
                    turn       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_sram_arbiter.sv
// Bench for ext_sram_arbiter: directed steps plus randomized transactions checked
// against a transaction-level reference memory and arbitration model.
module tb_ext_sram_arbiter;

    localparam int unsigned AW = 21;
    localparam int unsigned DW = 8;
    localparam int unsigned NC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] req, we, ack;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [DW-1:0] rdata, dq_o, dq_i;
    logic [AW-1:0] sram_addr;
    logic          dq_oe, we_n;

    logic [NC-1:0] req_f, we_f, ack_f;
    logic [NC*AW-1:0] addr_f;
    logic [NC*DW-1:0] wdata_f;
    logic [DW-1:0] rdata_f, dq_o_f, dq_i_f;
    logic [AW-1:0] sram_addr_f;
    logic          dq_oe_f, we_n_f;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:(2**AW)-1];
    logic [7:0] ref_mem [int];
    int last_win;

    always #5 clk = ~clk;

    ext_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC), .WAIT_CYCLES(2), .RR_MODE(1)) dut (
        .clk_chipset(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .SRAM_ADDR(sram_addr), .SRAM_DQ_O(dq_o),
        .SRAM_DQ_OE(dq_oe), .SRAM_DQ_I(dq_i), .SRAM_WE_n(we_n));

    ext_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC), .WAIT_CYCLES(2), .RR_MODE(0)) dut_f (
        .clk_chipset(clk), .reset(reset), .req(req_f), .we(we_f), .addr(addr_f), .wdata(wdata_f),
        .ack(ack_f), .rdata(rdata_f), .SRAM_ADDR(sram_addr_f), .SRAM_DQ_O(dq_o_f),
        .SRAM_DQ_OE(dq_oe_f), .SRAM_DQ_I(dq_i_f), .SRAM_WE_n(we_n_f));

    // Async SRAM model: write while WE_n low, combinational read.
    assign dq_i   = mem[sram_addr];
    assign dq_i_f = '0;
    always @(negedge clk) begin
        if (!we_n && dq_oe)
            mem[sram_addr] = dq_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("we_low_without_oe", 32'(!we_n && !dq_oe), 32'd0);
        check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    endtask

    function automatic logic [7:0] ref_read(input logic [20:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    // Waits for the ack of one access and checks latency, channel, bus phases and read data.
    task automatic txn_wait(input int ch, input bit w, input int lat,
                            input logic [20:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        int n;
        logic [15:0] oe_m, wl_m;
        logic [20:0] sa;
        logic [7:0]  sd;
        oe_m = '0; wl_m = '0; sa = '0; sd = '0;
        for (n = 1; n <= lat + 4; n++) begin
            step();
            oe_m[n] = dq_oe;
            wl_m[n] = !we_n;
            if (n == lat - 3) begin
                sa = sram_addr;
                sd = dq_o;
            end
            if (ack != '0) break;
        end
        check("ack_latency", 32'(n), 32'(lat));
        check("ack_channel", 32'(ack), 32'(1 << ch));
        check("setup_addr", 32'(sa), 32'(a));
        check("oe_phases", 32'(oe_m), w ? 32'(16'b11110 << (lat - 4)) : 32'd0);
        check("we_low_phases", 32'(wl_m), w ? 32'(16'b01100 << (lat - 4)) : 32'd0);
        if (w) check("write_data", 32'(sd), 32'(d));
        else   check("read_data", 32'(rdata), 32'(exp_rd));
    endtask

    task automatic set_ch(input int ch, input bit w, input logic [20:0] a, input logic [7:0] d);
        we[ch] = w;
        addr[ch*AW +: AW] = a;
        wdata[ch*DW +: DW] = d;
    endtask

    task automatic do_single(input int ch, input bit w, input logic [20:0] a, input logic [7:0] d);
        logic [7:0] e;
        e = ref_read(a);
        set_ch(ch, w, a, d);
        req[ch] = 1'b1;
        txn_wait(ch, w, 4, a, d, e);
        req[ch] = 1'b0;
        if (w) ref_mem[int'(a)] = d;
        last_win = ch;
        repeat (3) step();
    endtask

    task automatic do_dual(input bit w0, input logic [20:0] a0, input logic [7:0] d0,
                           input bit w1, input logic [20:0] a1, input logic [7:0] d1);
        int first, second;
        bit wf, ws;
        logic [20:0] af, as_;
        logic [7:0] df, ds;
        set_ch(0, w0, a0, d0);
        set_ch(1, w1, a1, d1);
        first  = (last_win + 1) % NC;
        second = 1 - first;
        wf = first == 0 ? w0 : w1;  af  = first == 0 ? a0 : a1;  df = first == 0 ? d0 : d1;
        ws = first == 0 ? w1 : w0;  as_ = first == 0 ? a1 : a0;  ds = first == 0 ? d1 : d0;
        req = 2'b11;
        txn_wait(first, wf, 4, af, df, ref_read(af));
        req[first] = 1'b0;
        if (wf) ref_mem[int'(af)] = df;
        txn_wait(second, ws, 6, as_, ds, ref_read(as_));
        req[second] = 1'b0;
        if (ws) ref_mem[int'(as_)] = ds;
        last_win = second;
        repeat (3) step();
    endtask

    initial begin
        logic [20:0] pool [8];
        int ev_cyc[$];
        int ev_ch[$];
        int acks;
        int exp_ch;

        for (int i = 0; i < 2**AW; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) pool[i] = {1'b1, 20'($urandom)};
        reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        req_f = '0; we_f = '0; addr_f = '0; wdata_f = '0;
        last_win = NC - 1;

        // Reset values and quiet idle
        step(); step();
        reset = 1'b0;
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_oe", 32'(dq_oe), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_o", 32'(dq_o), 32'd0);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack != '0) acks++;
        end
        check("idle_no_ack", 32'(acks), 32'd0);

        // Directed write then read-back on the other channel
        do_single(0, 1'b1, 21'h1ABCD, 8'h5A);
        check("sram_holds_write", 32'(mem[21'h1ABCD]), 32'h5A);
        check("rdata_kept_after_write", 32'(rdata), 32'd0);
        do_single(1, 1'b0, 21'h1ABCD, 8'h00);

        // Reset during the second ACCESS cycle of a write
        set_ch(0, 1'b1, 21'h00123, 8'hC3);
        req[0] = 1'b1;
        step(); step(); step();
        check("mid_access_we_low", 32'(we_n), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        req[0] = 1'b0;
        last_win = NC - 1;
        check("abort_we_n", 32'(we_n), 32'd1);
        check("abort_oe", 32'(dq_oe), 32'd0);
        check("abort_no_ack", 32'(ack), 32'd0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack != '0) acks++;
        end
        check("abort_no_late_ack", 32'(acks), 32'd0);
        do_single(0, 1'b0, 21'h1ABCD, 8'h00);

        // Round-robin with both requests held
        reset = 1'b1; step(); reset = 1'b0; step();
        last_win = NC - 1;
        set_ch(0, 1'b0, pool[0], 8'h00);
        set_ch(1, 1'b0, pool[1], 8'h00);
        req = 2'b11;
        for (int n = 1; n <= 22; n++) begin
            step();
            if (ack != '0) begin
                ev_cyc.push_back(n);
                ev_ch.push_back(ack == 2'b01 ? 0 : (ack == 2'b10 ? 1 : 99));
            end
        end
        req = '0;
        repeat (4) step();
        check("rr_ack_count", 32'(ev_cyc.size()), 32'd4);
        for (int k = 0; k < 4 && k < ev_cyc.size(); k++) begin
            exp_ch = (last_win + 1) % NC;
            last_win = exp_ch;
            check("rr_ack_cycle", 32'(ev_cyc[k]), 32'(4 + 6 * k));
            check("rr_ack_channel", 32'(ev_ch[k]), 32'(exp_ch));
        end

        // Fixed priority: ch1 served only after ch0 drops its request
        ev_cyc.delete(); ev_ch.delete();
        req_f = 2'b11;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (ack_f != '0) begin
                ev_cyc.push_back(n);
                ev_ch.push_back(ack_f == 2'b01 ? 0 : (ack_f == 2'b10 ? 1 : 99));
                if (ev_cyc.size() == 3) req_f[0] = 1'b0;
                if (ack_f[1]) req_f[1] = 1'b0;
            end
        end
        req_f = '0;
        check("fp_ack_count", 32'(ev_cyc.size()), 32'd4);
        for (int k = 0; k < 4 && k < ev_cyc.size(); k++) begin
            check("fp_ack_cycle", 32'(ev_cyc[k]), 32'(4 + 6 * k));
            check("fp_ack_channel", 32'(ev_ch[k]), k < 3 ? 32'd0 : 32'd1);
        end

        // Randomized single and contending transactions
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_dual(1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom),
                        1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom));
            else
                do_single(int'($urandom_range(0, 1)), 1'($urandom),
                          pool[$urandom_range(0, 7)], 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
